// File: rtl/interrupt_sequencer_pkg.sv
// Shared types for the interrupt entry sequencer: FSM states, push-select codes,
// and the decode from state to registered sequencer outputs.
package interrupt_sequencer_pkg;

   localparam int STACK_W = 16;
   localparam int DCNT_W  = 3;

   typedef enum logic [3:0] {
      IDLE, PEND, DRAIN, PUSH_HI, PUSH_LO, PUSH_CCR, VEC_HI, VEC_LO, RESUME
   } int_state_t;

   localparam logic [1:0] PSEL_NONE = 2'b00;
   localparam logic [1:0] PSEL_PCH  = 2'b01;
   localparam logic [1:0] PSEL_PCL  = 2'b10;
   localparam logic [1:0] PSEL_CCR  = 2'b11;

   typedef struct packed {
      logic               freeze;
      logic               inject_nop;
      logic               stack_wr;
      logic [1:0]         push_sel;
      logic               vec_rd;
      logic [STACK_W-1:0] vec_addr;
      logic               pc_load_hi;
      logic               pc_load_lo;
      logic               flush;
   } seq_out_t;

   // Fetch stays frozen through the vector reads so only pc_load_* move the PC.
   function automatic seq_out_t decode_outputs(int_state_t st, logic [STACK_W-1:0] vec_base);
      seq_out_t o;
      o = '0;
      case (st)
         DRAIN: begin
            o.freeze = 1'b1; o.inject_nop = 1'b1;
         end
         PUSH_HI: begin
            o.freeze = 1'b1; o.inject_nop = 1'b1; o.stack_wr = 1'b1; o.push_sel = PSEL_PCH;
         end
         PUSH_LO: begin
            o.freeze = 1'b1; o.inject_nop = 1'b1; o.stack_wr = 1'b1; o.push_sel = PSEL_PCL;
         end
         PUSH_CCR: begin
            o.freeze = 1'b1; o.inject_nop = 1'b1; o.stack_wr = 1'b1; o.push_sel = PSEL_CCR;
         end
         VEC_HI: begin
            o.freeze = 1'b1; o.inject_nop = 1'b1; o.vec_rd = 1'b1;
            o.vec_addr = vec_base; o.pc_load_hi = 1'b1;
         end
         VEC_LO: begin
            o.freeze = 1'b1; o.inject_nop = 1'b1; o.vec_rd = 1'b1;
            o.vec_addr = vec_base + 16'd1; o.pc_load_lo = 1'b1;
         end
         RESUME: o.flush = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Pipeline-side bundle of the interrupt sequencer: request/boundary inputs and
// freeze/flush/stack/vector overrides. slave = sequencer, master = pipeline.
interface interrupt_sequencer_if #(
   parameter int PC_WIDTH = 32
);
   logic                int_req;
   logic                multi_cycle_id;
   logic                load_use;
   logic                rti_done;
   logic [PC_WIDTH-1:0] pc_in;
   logic                int_ack;
   logic                freeze;
   logic                inject_nop;
   logic                stack_wr;
   logic [1:0]          push_sel;
   logic [PC_WIDTH-1:0] saved_pc;
   logic                vec_rd;
   logic [15:0]         vec_addr;
   logic                pc_load_hi;
   logic                pc_load_lo;
   logic                flush;
   logic                in_isr;

   modport master (
      output int_req, multi_cycle_id, load_use, rti_done, pc_in,
      input  int_ack, freeze, inject_nop, stack_wr, push_sel, saved_pc,
             vec_rd, vec_addr, pc_load_hi, pc_load_lo, flush, in_isr
   );

   modport slave (
      input  int_req, multi_cycle_id, load_use, rti_done, pc_in,
      output int_ack, freeze, inject_nop, stack_wr, push_sel, saved_pc,
             vec_rd, vec_addr, pc_load_hi, pc_load_lo, flush, in_isr
   );
endinterface

// File: rtl/interrupt_sequencer_drain_counter.sv
// Bubble counter for the drain phase: loads on accept, counts down while draining,
// zero flag ends the drain.
module interrupt_sequencer_drain_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      cnt_q <= '0;
      else if (load_i)               cnt_q <= load_val_i;
      else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: pend -> accept at a safe boundary -> drain -> push PC/CCR
// -> load vector -> resume. Define INT_NEST_EN for up to three nested handlers.
module interrupt_sequencer
   import interrupt_sequencer_pkg::*;
#(
   parameter int          PC_WIDTH     = 32,
   parameter int          DRAIN_CYCLES = 3,
   parameter logic [15:0] VECTOR_ADDR  = 16'h0
) (
   input  logic                 clk,
   input  logic                 rst,
   interrupt_sequencer_if.slave bus
);

   localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

   int_state_t          state_q, state_d;
   seq_out_t            out_q;
   logic                pending_q;
   logic [PC_WIDTH-1:0] saved_pc_q;
   logic                accept, resume, can_take, drain_zero, in_isr;

   assign accept = (state_q == PEND) && !bus.multi_cycle_id && !bus.load_use;
   assign resume = (state_q == RESUME);

`ifdef INT_NEST_EN
   logic [1:0] depth_q;
   logic       depth_dec;

   assign depth_dec = bus.rti_done && (depth_q != 2'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) depth_q <= 2'd0;
      else      depth_q <= depth_q + {1'b0, resume} - {1'b0, depth_dec};
   end

   // Full nesting depth parks new requests in pending until a handler returns.
   assign can_take = (depth_q != 2'd3);
   assign in_isr   = (depth_q != 2'd0);
`else
   logic in_isr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              in_isr_q <= 1'b0;
      else if (resume)       in_isr_q <= 1'b1;
      else if (bus.rti_done) in_isr_q <= 1'b0;
   end

   assign can_take = !in_isr_q;
   assign in_isr   = in_isr_q;
`endif

   interrupt_sequencer_drain_counter #(.W(DCNT_W)) u_drain (
      .clk        (clk),
      .rst        (rst),
      .load_i     (accept),
      .load_val_i (DRAIN_LOAD),
      .dec_i      (state_q == DRAIN),
      .zero_o     (drain_zero)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (pending_q && can_take) state_d = PEND;
         PEND:     if (accept)                state_d = DRAIN;
         DRAIN:    if (drain_zero)            state_d = PUSH_HI;
         PUSH_HI:  state_d = PUSH_LO;
         PUSH_LO:  state_d = PUSH_CCR;
         PUSH_CCR: state_d = VEC_HI;
         VEC_HI:   state_d = VEC_LO;
         VEC_LO:   state_d = RESUME;
         RESUME:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         pending_q  <= 1'b0;
         saved_pc_q <= '0;
         out_q      <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= bus.int_req | (pending_q & ~accept);
         if (accept) saved_pc_q <= bus.pc_in;
         out_q     <= decode_outputs(state_d, VECTOR_ADDR);
      end
   end

   assign bus.int_ack    = accept;
   assign bus.freeze     = out_q.freeze;
   assign bus.inject_nop = out_q.inject_nop;
   assign bus.stack_wr   = out_q.stack_wr;
   assign bus.push_sel   = out_q.push_sel;
   assign bus.saved_pc   = saved_pc_q;
   assign bus.vec_rd     = out_q.vec_rd;
   assign bus.vec_addr   = out_q.vec_addr;
   assign bus.pc_load_hi = out_q.pc_load_hi;
   assign bus.pc_load_lo = out_q.pc_load_lo;
   assign bus.flush      = out_q.flush;
   assign bus.in_isr     = in_isr;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: phase-count reference model checked every cycle,
// directed literal scenarios, then randomized traffic.
module tb_interrupt_sequencer;

   localparam int          D  = 3;
   localparam logic [15:0] VA = 16'h0;
   localparam int          LAST = D + 6;
`ifdef INT_NEST_EN
   localparam int MAXD = 3;
   localparam bit NEST = 1'b1;
`else
   localparam int MAXD = 1;
   localparam bit NEST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   interrupt_sequencer_if #(.PC_WIDTH(32)) bus();

   interrupt_sequencer #(.PC_WIDTH(32), .DRAIN_CYCLES(D), .VECTOR_ADDR(VA)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: m_k counts cycles since accept (0 = no sequence running),
   // m_wait marks the cycle(s) a request is waiting for a safe boundary.
   bit          m_pend = 1'b0;
   bit          m_wait = 1'b0;
   int          m_k = 0;
   int          m_depth = 0;
   logic [31:0] m_saved = '0;

   always @(posedge clk or negedge rst) begin : model
      bit acc;
      int nk, nd;
      if (!rst) begin
         m_pend <= 1'b0; m_wait <= 1'b0; m_k <= 0; m_depth <= 0; m_saved <= '0;
      end else begin
         acc = m_wait && !bus.multi_cycle_id && !bus.load_use;
         nk  = (m_k == LAST) ? 0 : (m_k != 0 ? m_k + 1 : 0);
         nd  = m_depth;
         if (bus.rti_done && nd > 0) nd = nd - 1;
         if (m_k == LAST) nd = NEST ? nd + 1 : 1;
         if (acc) begin
            nk = 1;
            m_saved <= bus.pc_in;
         end
         if (acc)                                                   m_wait <= 1'b0;
         else if (!m_wait && m_k == 0 && m_pend && m_depth < MAXD)  m_wait <= 1'b1;
         m_pend  <= bus.int_req || (m_pend && !acc);
         m_k     <= nk;
         m_depth <= nd;
      end
   end

   always @(negedge clk) begin : cmp
      int  k;
      bit  push;
      k    = m_k;
      push = (k >= D + 1) && (k <= D + 3);
      if (chk_en) begin
         chk("int_ack",    64'(bus.int_ack),    64'(m_wait && !bus.multi_cycle_id && !bus.load_use));
         chk("freeze",     64'(bus.freeze),     64'(k >= 1 && k <= D + 5));
         chk("inject_nop", 64'(bus.inject_nop), 64'(k >= 1 && k <= D + 5));
         chk("stack_wr",   64'(bus.stack_wr),   64'(push));
         chk("push_sel",   64'(bus.push_sel),   push ? 64'(k - D) : 64'd0);
         chk("vec_rd",     64'(bus.vec_rd),     64'(k == D + 4 || k == D + 5));
         chk("vec_addr",   64'(bus.vec_addr),   (k == D + 4) ? 64'(VA) : (k == D + 5) ? 64'(VA + 16'd1) : 64'd0);
         chk("pc_load_hi", 64'(bus.pc_load_hi), 64'(k == D + 4));
         chk("pc_load_lo", 64'(bus.pc_load_lo), 64'(k == D + 5));
         chk("flush",      64'(bus.flush),      64'(k == LAST));
         chk("in_isr",     64'(bus.in_isr),     64'(m_depth != 0));
         chk("saved_pc",   64'(bus.saved_pc),   64'(m_saved));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rti_pulse();
      if (m_depth > 0 && m_k != LAST) begin
         bus.rti_done = 1'b1;
         step();
         bus.rti_done = 1'b0;
      end else begin
         step();
      end
   endtask

   task automatic blocked_test(input bit use_lu, input logic [31:0] pc);
      int acks;
      acks = 0;
      bus.pc_in = pc;
      bus.int_req = 1'b1;
      if (use_lu) bus.load_use = 1'b1; else bus.multi_cycle_id = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         acks += int'(bus.int_ack);
         step();
         bus.int_req = 1'b0;
      end
      chk(use_lu ? "lu_blocks_ack" : "mc_blocks_ack", 64'(acks), 64'd0);
      bus.load_use = 1'b0;
      bus.multi_cycle_id = 1'b0;
      @(negedge clk);
      chk(use_lu ? "lu_release_ack" : "mc_release_ack", 64'(bus.int_ack), 64'd1);
      repeat (LAST + 2) step();
      rti_pulse();
      rti_pulse();
   endtask

   initial begin
      int acks, got;
      bus.int_req = 1'b0; bus.multi_cycle_id = 1'b0; bus.load_use = 1'b0;
      bus.rti_done = 1'b0; bus.pc_in = '0;
      #2 rst = 1'b0;
      chk_en = 1'b1;
      step(); step();
      rst = 1'b1;
      @(negedge clk);
      chk("reset_outputs", 64'({bus.int_ack, bus.freeze, bus.stack_wr, bus.flush, bus.in_isr, bus.vec_rd}), 64'd0);
      step();

      // Single pulse on an idle pipe: cycle 0 = the cycle int_req is high.
      bus.pc_in = 32'h0001_0040;
      bus.int_req = 1'b1;
      for (int c = 0; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) chk("lit_noack_c1", 64'(bus.int_ack), 64'd0);
         if (c == 2) chk("lit_ack_c2", 64'(bus.int_ack), 64'd1);
         if (c == 3) chk("lit_freeze_c3", 64'({bus.freeze, bus.inject_nop}), 64'h3);
         if (c >= 6 && c <= 8)
            chk($sformatf("lit_push_c%0d", c), 64'({bus.stack_wr, bus.push_sel}), 64'(4 + c - 5));
         if (c == 9)  chk("lit_vec_hi", 64'({bus.vec_rd, bus.pc_load_hi, bus.vec_addr}), 64'h3_0000);
         if (c == 10) chk("lit_vec_lo", 64'({bus.vec_rd, bus.pc_load_lo, bus.vec_addr}), 64'h3_0001);
         if (c == 11) chk("lit_flush_c11", 64'(bus.flush), 64'd1);
         if (c == 12) chk("lit_saved_pc", 64'({bus.in_isr, bus.saved_pc}), 64'h1_0001_0040);
         step();
         bus.int_req = 1'b0;
      end
      rti_pulse();
      @(negedge clk);
      chk("lit_rti_clears", 64'(bus.in_isr), 64'(NEST ? 0 : 0));
      step();

      blocked_test(1'b0, 32'hA5A5_1234);
      blocked_test(1'b1, 32'h0000_BEEF);

      // Second request lands during DRAIN of the first sequence.
      bus.pc_in = 32'h0000_0100;
      bus.int_req = 1'b1;
      step(); bus.int_req = 1'b0;
      step(); step(); step();
      bus.int_req = 1'b1;
      step(); bus.int_req = 1'b0;
      repeat (7) step();
      acks = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         acks += int'(bus.int_ack);
         step();
      end
      if (NEST) begin
         chk("nest_second_ack", 64'(acks), 64'd1);
      end else begin
         chk("held_in_handler", 64'(acks), 64'd0);
         rti_pulse();
         got = 0;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.int_ack) got = 1;
            step();
         end
         chk("held_then_ack", 64'(got), 64'd1);
      end
      repeat (LAST + 2) step();
      rti_pulse(); rti_pulse(); rti_pulse();

      // rti_done in the same cycle as the accept.
      bus.pc_in = 32'h0000_7777;
      bus.int_req = 1'b1;
      bus.multi_cycle_id = 1'b1;
      step(); bus.int_req = 1'b0;
      step(); step();
      bus.multi_cycle_id = 1'b0;
      bus.rti_done = (m_depth > 0);
      @(negedge clk);
      chk("coincident_ack", 64'(bus.int_ack), 64'd1);
      step();
      bus.rti_done = 1'b0;
      repeat (LAST + 1) step();
      rti_pulse(); rti_pulse(); rti_pulse();

`ifdef INT_NEST_EN
      for (int n = 0; n < 3; n++) begin
         bus.int_req = 1'b1;
         step(); bus.int_req = 1'b0;
         repeat (LAST + 2) step();
      end
      bus.int_req = 1'b1;
      step(); bus.int_req = 1'b0;
      acks = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         acks += int'(bus.int_ack);
         step();
      end
      chk("depth3_holds", 64'(acks), 64'd0);
      rti_pulse();
      got = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.int_ack) got = 1;
         step();
      end
      chk("depth3_release", 64'(got), 64'd1);
      repeat (LAST + 2) step();
`endif

      // Reset asserted in the middle of PUSH_LO (cycle 7 after the request).
      bus.int_req = 1'b1;
      step(); bus.int_req = 1'b0;
      repeat (6) step();
      @(negedge clk);
      chk("pre_reset_push_lo", 64'({bus.stack_wr, bus.push_sel}), 64'h6);
      #1 rst = 1'b0;
      #1 chk("async_reset_outputs", 64'({bus.freeze, bus.stack_wr, bus.push_sel, bus.in_isr, bus.int_ack}), 64'd0);
      step();
      rst = 1'b1;
      acks = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         acks += int'(bus.int_ack) + int'(bus.freeze);
         step();
      end
      chk("post_reset_idle", 64'(acks), 64'd0);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         bus.int_req        = ($urandom_range(0, 15) == 0);
         bus.multi_cycle_id = ($urandom_range(0, 3) == 0);
         bus.load_use       = ($urandom_range(0, 4) == 0);
         bus.pc_in          = $urandom;
         bus.rti_done       = (m_depth > 0) && (m_k != LAST) && ($urandom_range(0, 19) == 0);
         step();
      end
      bus.int_req = 1'b0; bus.rti_done = 1'b0;
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
